cmd_uart_wrapper: RTL and testbench

CMD_UART_WRAPPER -- requirements
Module: cmd_uart_wrapper

---
 rtl/osc_cmd_pkg.sv | 20 ++
 rtl/cmd_uart_wrapper_if.sv | 25 ++
 rtl/cmd_timeout_cnt.sv | 25 ++
 rtl/cmd_uart_wrapper.sv | 117 +++++++++++
 tb/tb_cmd_uart_wrapper.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/osc_cmd_pkg.sv
// osc_cmd_pkg: shared command opcodes, response bytes and FSM state types for the command UART wrapper
package osc_cmd_pkg;

    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] TRIG_LVL = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] TRIG_CFG = 8'h06;
    localparam logic [7:0] CH_CFG   = 8'h07;
    localparam logic [7:0] EEP_WR   = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    localparam logic [7:0] POS_ACK  = 8'hA5;
    localparam logic [7:0] NEG_ACK  = 8'hEE;

    typedef enum logic [1:0] {RX_B0, RX_B1, RX_B2, HOLD} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

endpackage

// File: rtl/cmd_uart_wrapper_if.sv
// cmd_uart_wrapper_if: UART byte-core and command-processor signals of the command wrapper
interface cmd_uart_wrapper_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        input  rx_rdy, rx_data, tx_done, clr_cmd_rdy, resp_data, send_resp,
        output clr_rx_rdy, tx_data, trmt, cmd, cmd_rdy, resp_sent
    );

    modport slave (
        output rx_rdy, rx_data, tx_done, clr_cmd_rdy, resp_data, send_resp,
        input  clr_rx_rdy, tx_data, trmt, cmd, cmd_rdy, resp_sent
    );
endinterface

// File: rtl/cmd_timeout_cnt.sv
// cmd_timeout_cnt: saturating idle-cycle counter flagging an inter-byte timeout
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] r_cnt;

    // count enabled idle cycles, stopping at the limit so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            r_cnt <= '0;
        else if (en && r_cnt != LIMIT)
            r_cnt <= r_cnt + W'(1);
    end

    assign expired = (r_cnt == LIMIT);
endmodule

// File: rtl/cmd_uart_wrapper.sv
// cmd_uart_wrapper: assembles 3-byte commands from the UART receiver and sends single-byte responses
module cmd_uart_wrapper
    import osc_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic               clk,
    input logic               rst_n,
    cmd_uart_wrapper_if.master uart
);
    rx_state_t   r_rx_state, w_rx_next;
    tx_state_t   r_tx_state, w_tx_next;
    logic [23:0] r_cmd;
    logic        r_cmd_rdy;
    logic [7:0]  r_tx_data;
    logic        r_trmt;
    logic        r_resp_sent;
    logic        w_consume;
    logic        w_tmo_en;
    logic        w_tmo_clr;
    logic        w_expired;
    logic        w_load;
    logic        w_done;

    // idle cycles only count while a command is partially received
    assign w_tmo_clr = w_consume || r_rx_state == RX_B0 || r_rx_state == HOLD;

    cmd_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_tmo_clr),
        .en      (w_tmo_en),
        .expired (w_expired)
    );

    // receive next-state: an expired timeout wins over a byte arriving the same cycle,
    // which then stays pending and becomes byte 0 of a fresh command
    always_comb begin
        w_rx_next = r_rx_state;
        w_consume = 1'b0;
        w_tmo_en  = 1'b0;
        case (r_rx_state)
            RX_B0: begin
                w_consume = uart.rx_rdy;
                w_rx_next = uart.rx_rdy ? RX_B1 : RX_B0;
            end
            RX_B1, RX_B2: begin
                w_tmo_en  = !uart.rx_rdy;
                w_consume = uart.rx_rdy && !w_expired;
                w_rx_next = w_expired ? RX_B0 :
                            !uart.rx_rdy ? r_rx_state :
                            (r_rx_state == RX_B1) ? RX_B2 : HOLD;
            end
            default: w_rx_next = uart.clr_cmd_rdy ? RX_B0 : HOLD;
        endcase
    end

    // receive state, command bytes (MSB first) and the cmd_rdy level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_state <= RX_B0;
            r_cmd      <= '0;
            r_cmd_rdy  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            if (w_consume)
                r_cmd <= (r_rx_state == RX_B0) ? {uart.rx_data, r_cmd[15:0]} :
                         (r_rx_state == RX_B1) ? {r_cmd[23:16], uart.rx_data, r_cmd[7:0]} :
                                                 {r_cmd[23:8], uart.rx_data};
            if (w_consume && r_rx_state == RX_B2)
                r_cmd_rdy <= 1'b1;
            else if (r_rx_state == HOLD && uart.clr_cmd_rdy)
                r_cmd_rdy <= 1'b0;
        end
    end

    // transmit next-state: a send arriving with tx_done chains straight into the next byte
    always_comb begin
        w_tx_next = r_tx_state;
        w_load    = 1'b0;
        w_done    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_load    = uart.send_resp;
                w_tx_next = uart.send_resp ? TX_BUSY : TX_IDLE;
            end
            default: begin
                w_done    = uart.tx_done;
                w_load    = uart.tx_done && uart.send_resp;
                w_tx_next = (uart.tx_done && !uart.send_resp) ? TX_IDLE : TX_BUSY;
            end
        endcase
    end

    // transmit state, latched response byte and the trmt/resp_sent pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state  <= TX_IDLE;
            r_tx_data   <= '0;
            r_trmt      <= 1'b0;
            r_resp_sent <= 1'b0;
        end else begin
            r_tx_state  <= w_tx_next;
            if (w_load)
                r_tx_data <= uart.resp_data;
            r_trmt      <= w_load;
            r_resp_sent <= w_done;
        end
    end

    assign uart.clr_rx_rdy = w_consume && rst_n;
    assign uart.cmd        = r_cmd;
    assign uart.cmd_rdy    = r_cmd_rdy;
    assign uart.tx_data    = r_tx_data;
    assign uart.trmt       = r_trmt;
    assign uart.resp_sent  = r_resp_sent;
endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// tb_cmd_uart_wrapper: self-checking bench for cmd_uart_wrapper with a queue-based command model
module tb_cmd_uart_wrapper;
    localparam int TMO = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int n_clr = 0;
    int n_trmt = 0;
    int n_sent = 0;
    int n_cmd = 0;
    logic prev_rdy = 1'b0;

    cmd_uart_wrapper_if bus();

    cmd_uart_wrapper #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .uart  (bus)
    );

    always #5 clk = ~clk;

    // pulse/event counters sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        n_clr    <= n_clr + int'(bus.clr_rx_rdy);
        n_trmt   <= n_trmt + int'(bus.trmt);
        n_sent   <= n_sent + int'(bus.resp_sent);
        n_cmd    <= n_cmd + int'(bus.cmd_rdy && !prev_rdy);
        prev_rdy <= bus.cmd_rdy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a byte after 'gap' idle cycles and wait (bounded) for it to be consumed
    task automatic rx_byte(input logic [7:0] b, input int gap, output logic rdy_at_consume);
        int n;
        repeat (gap) tick();
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        n = 0;
        @(negedge clk);
        while (bus.clr_rx_rdy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        rdy_at_consume = bus.cmd_rdy;
        n_chk++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL rx_consume_wait: byte %h not consumed, waited %0d cycles, limit 40", b, n);
        end
        tick();
        bus.rx_rdy = 1'b0;
    endtask

    task automatic clear_cmd(input int d);
        repeat (d) tick();
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        n_chk++;
        if (bus.cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_cmd_rdy: cmd_rdy=%b expected 0", bus.cmd_rdy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_chk++;
        if ({bus.cmd, bus.cmd_rdy, bus.tx_data, bus.trmt, bus.resp_sent, bus.clr_rx_rdy} !== 36'h0) begin
            n_fail++;
            $display("FAIL %s: cmd=%h cmd_rdy=%b tx_data=%h trmt=%b resp_sent=%b clr_rx_rdy=%b expected all zero",
                     tag, bus.cmd, bus.cmd_rdy, bus.tx_data, bus.trmt, bus.resp_sent, bus.clr_rx_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_values("reset_values");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_cmd();
        logic r;
        int c0;
        c0 = n_clr;
        rx_byte(8'h04, 0, r);
        rx_byte(8'h01, 1, r);
        n_chk++;
        if (bus.cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rdy_early: cmd_rdy=%b expected 0", bus.cmd_rdy);
        end
        rx_byte(8'h2C, 0, r);
        n_chk++;
        if (r !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rdy_same_cycle: cmd_rdy=%b expected 0 in consume cycle", r);
        end
        n_chk++;
        if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 24'h04012C) begin
            n_fail++;
            $display("FAIL basic_cmd: cmd=%h rdy=%b expected 04012c rdy=1", bus.cmd, bus.cmd_rdy);
        end
        n_chk++;
        if (n_clr - c0 !== 3) begin
            n_fail++;
            $display("FAIL basic_clr_count: %0d pulses expected 3", n_clr - c0);
        end
    endtask

    task automatic test_hold();
        logic r;
        int c0;
        c0 = n_clr;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h07;
        repeat (20) tick();
        n_chk++;
        if (n_clr !== c0 || bus.cmd !== 24'h04012C || bus.cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_stable: clr pulses=%0d cmd=%h rdy=%b expected 0 04012c 1", n_clr - c0, bus.cmd, bus.cmd_rdy);
        end
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.clr_rx_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_clear_first: clr_rx_rdy=%b expected 0", bus.clr_rx_rdy);
        end
        tick();
        bus.clr_cmd_rdy = 1'b0;
        n_chk++;
        if (bus.cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_rdy_drop: cmd_rdy=%b expected 0", bus.cmd_rdy);
        end
        @(negedge clk);
        n_chk++;
        if (bus.clr_rx_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_byte0: clr_rx_rdy=%b expected 1", bus.clr_rx_rdy);
        end
        tick();
        bus.rx_rdy = 1'b0;
        rx_byte(8'hA1, 0, r);
        rx_byte(8'hB2, 2, r);
        n_chk++;
        if (bus.cmd !== 24'h07A1B2 || bus.cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_next_cmd: cmd=%h rdy=%b expected 07a1b2 1", bus.cmd, bus.cmd_rdy);
        end
        clear_cmd(0);
    endtask

    task automatic test_timeout();
        logic r;
        int k0;
        k0 = n_cmd;
        rx_byte(8'h02, 0, r);
        rx_byte(8'h09, TMO, r);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        rx_byte(8'h05, 0, r);
        rx_byte(8'h11, 0, r);
        n_chk++;
        if (bus.cmd !== 24'h090511 || bus.cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_cmd: cmd=%h rdy=%b expected 090511 1", bus.cmd, bus.cmd_rdy);
        end
        clear_cmd(1);
        n_chk++;
        if (n_cmd - k0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_cmd_count: %0d commands expected 1", n_cmd - k0);
        end
    endtask

    task automatic test_tx_single();
        int s0;
        int t0;
        s0 = n_sent;
        t0 = n_trmt;
        bus.resp_data = 8'hA5;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        n_chk++;
        if (bus.tx_data !== 8'hA5 || bus.trmt !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_start: tx_data=%h trmt=%b expected a5 1", bus.tx_data, bus.trmt);
        end
        tick();
        n_chk++;
        if (bus.trmt !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_trmt_width: trmt=%b expected 0", bus.trmt);
        end
        bus.resp_data = 8'h3C;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        repeat (27) tick();
        n_chk++;
        if (bus.tx_data !== 8'hA5 || n_trmt - t0 !== 1 || n_sent !== s0) begin
            n_fail++;
            $display("FAIL tx_busy_hold: tx_data=%h trmt=%0d sent=%0d expected a5 1 0", bus.tx_data, n_trmt - t0, n_sent - s0);
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        n_chk++;
        if (bus.resp_sent !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_resp_sent: resp_sent=%b expected 1", bus.resp_sent);
        end
        tick();
        n_chk++;
        if (bus.resp_sent !== 1'b0 || n_sent - s0 !== 1) begin
            n_fail++;
            $display("FAIL tx_sent_pulse: resp_sent=%b count=%0d expected 0 1", bus.resp_sent, n_sent - s0);
        end
    endtask

    task automatic test_back_to_back();
        bus.resp_data = 8'h5A;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        repeat (5) tick();
        bus.resp_data = 8'hEE;
        bus.send_resp = 1'b1;
        bus.tx_done   = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        bus.tx_done   = 1'b0;
        n_chk++;
        if (bus.resp_sent !== 1'b1 || bus.trmt !== 1'b1 || bus.tx_data !== 8'hEE) begin
            n_fail++;
            $display("FAIL b2b_chain: resp_sent=%b trmt=%b tx_data=%h expected 1 1 ee", bus.resp_sent, bus.trmt, bus.tx_data);
        end
        repeat (3) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        n_chk++;
        if (bus.resp_sent !== 1'b1 || bus.trmt !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_finish: resp_sent=%b trmt=%b expected 1 0", bus.resp_sent, bus.trmt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic r;
        int s0;
        bus.resp_data = 8'h77;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        rx_byte(8'h31, 0, r);
        rx_byte(8'h32, 0, r);
        s0 = n_sent;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values("reset_mid_values");
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        n_chk++;
        if (n_sent !== s0) begin
            n_fail++;
            $display("FAIL reset_mid_no_sent: %0d resp_sent pulses expected 0", n_sent - s0);
        end
        rx_byte(8'h40, 0, r);
        rx_byte(8'h41, 1, r);
        rx_byte(8'h42, 0, r);
        n_chk++;
        if (bus.cmd !== 24'h404142 || bus.cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_cmd: cmd=%h rdy=%b expected 404142 1", bus.cmd, bus.cmd_rdy);
        end
        clear_cmd(0);
    endtask

    // random byte stream; the model drops any partial command preceded by a gap of TMO or more
    task automatic test_random_rx();
        logic r;
        logic [7:0] part[$];
        logic [7:0] b;
        logic [23:0] exp_cmd;
        int gap;
        int done;
        done = 0;
        while (done < 8) begin
            b   = 8'($urandom);
            gap = ($urandom_range(0, 3) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 3);
            if (part.size() > 0 && gap >= TMO)
                part.delete();
            rx_byte(b, gap, r);
            part.push_back(b);
            if (part.size() == 3) begin
                exp_cmd = {part[0], part[1], part[2]};
                part.delete();
                done++;
                n_chk++;
                if (bus.cmd !== exp_cmd || bus.cmd_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random_cmd_%0d: cmd=%h rdy=%b expected %h 1", done, bus.cmd, bus.cmd_rdy, exp_cmd);
                end
                clear_cmd($urandom_range(0, 3));
            end
        end
    endtask

    // random send/done pattern against an idle/busy model of the transmitter
    task automatic test_random_tx();
        logic busy;
        logic [7:0] exp_tx;
        logic [7:0] b;
        logic do_send;
        logic do_done;
        logic exp_sent;
        logic exp_trmt;
        busy   = 1'b0;
        exp_tx = 8'h00;
        for (int i = 0; i < 16; i++) begin
            b        = 8'($urandom);
            do_send  = ($urandom_range(0, 2) != 0);
            do_done  = ($urandom_range(0, 1) != 0);
            exp_sent = busy && do_done;
            exp_trmt = do_send && (!busy || do_done);
            if (exp_trmt)
                exp_tx = b;
            busy = exp_trmt ? 1'b1 : (do_done ? 1'b0 : busy);
            bus.resp_data = b;
            bus.send_resp = do_send;
            bus.tx_done   = do_done;
            tick();
            bus.send_resp = 1'b0;
            bus.tx_done   = 1'b0;
            n_chk++;
            if (bus.resp_sent !== exp_sent || bus.trmt !== exp_trmt || bus.tx_data !== exp_tx) begin
                n_fail++;
                $display("FAIL random_tx_%0d: resp_sent=%b trmt=%b tx_data=%h expected %b %b %h",
                         i, bus.resp_sent, bus.trmt, bus.tx_data, exp_sent, exp_trmt, exp_tx);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.tx_done     = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp_data   = 8'h00;
        bus.send_resp   = 1'b0;
        test_reset();
        test_basic_cmd();
        test_hold();
        test_timeout();
        test_tx_single();
        test_back_to_back();
        test_reset_mid();
        test_random_tx();
        test_random_rx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
